// File: rtl/pixart_emu.sv
`default_nettype none
// ============================================================================
// Module   : pixart_emu
// Purpose  : I2C target emulating the PixArt IR camera: accepts register
//            writes and serves 16-byte blob reports from input ports.
//            Optional PIXART_EMU_SNAPSHOT_EN latches blob inputs per report.
// Revision : 1.0  initial release
// ============================================================================
module pixart_emu #(
    parameter logic [6:0] I2C_ADDR    = 7'h58,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [9:0] blob_x,
    input  logic [9:0] blob_y,
    input  logic [3:0] blob_size,
    input  logic       blob_valid,
    output logic       cfg_wr,
    output logic [7:0] cfg_addr,
    output logic [7:0] cfg_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_BYTE  = 3'd5,
        ST_RD_ACK   = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_q;
    logic                   sda_q;
    logic [SYNC_STAGES:0]   armed;

    // Edges are suppressed until the chain holds real pad samples, so a
    // reset in the middle of a transfer cannot fake a START or STOP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            armed    <= '0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_q    <= scl_sync[SYNC_STAGES-1];
            sda_q    <= sda_sync[SYNC_STAGES-1];
            armed    <= {armed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    logic scl_s, sda_s, live;
    logic scl_rise, scl_fall, bus_start, bus_stop;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign live      = armed[SYNC_STAGES];
    assign scl_rise  = live &  scl_s & ~scl_q;
    assign scl_fall  = live & ~scl_s &  scl_q;
    assign bus_start = live &  scl_s &  scl_q &  sda_q & ~sda_s;
    assign bus_stop  = live &  scl_s &  scl_q & ~sda_q &  sda_s;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic       rw;
    logic       ptr_loaded;
    logic [7:0] ptr;
    logic [3:0] idx;
    logic       rd_hit;
    logic [7:0] wr_byte;

    assign rd_hit  = (state == ST_ADDR) & scl_fall & (bit_cnt == 4'd8) &
                     (shreg[7:1] == I2C_ADDR) & shreg[0];
    assign wr_byte = {shreg[6:0], sda_s};

    logic [9:0] src_x;
    logic [9:0] src_y;
    logic [3:0] src_size;
    logic       src_valid;

`ifdef PIXART_EMU_SNAPSHOT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_x     <= '0;
            src_y     <= '0;
            src_size  <= '0;
            src_valid <= 1'b0;
        end else if (rd_hit) begin
            src_x     <= blob_x;
            src_y     <= blob_y;
            src_size  <= blob_size;
            src_valid <= blob_valid;
        end
    end
`else
    assign src_x     = blob_x;
    assign src_y     = blob_y;
    assign src_size  = blob_size;
    assign src_valid = blob_valid;
`endif

    logic [3:0] load_idx;
    logic [7:0] next_byte;

    always_comb begin
        load_idx  = (state == ST_ADDR_ACK) ? 4'd0 : idx + 4'd1;
        next_byte = 8'hFF;
        case (load_idx)
            4'd0:    next_byte = 8'h00;
            4'd1:    if (src_valid) next_byte = src_x[7:0];
            4'd2:    if (src_valid) next_byte = src_y[7:0];
            4'd3:    if (src_valid) next_byte = {src_y[9:8], src_x[9:8], src_size};
            default: next_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 4'd0;
            shreg      <= 8'h00;
            rw         <= 1'b0;
            ptr_loaded <= 1'b0;
            ptr        <= 8'h00;
            idx        <= 4'd0;
            sda_oe     <= 1'b0;
            cfg_wr     <= 1'b0;
            cfg_addr   <= 8'h00;
            cfg_data   <= 8'h00;
            busy       <= 1'b0;
        end else begin
            cfg_wr <= 1'b0;
            if (bus_stop) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (bus_start) begin
                state      <= ST_ADDR;
                bit_cnt    <= 4'd0;
                sda_oe     <= 1'b0;
                ptr_loaded <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= wr_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shreg[7:1] == I2C_ADDR) begin
                                state  <= ST_ADDR_ACK;
                                rw     <= shreg[0];
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw) begin
                                state  <= ST_RD_BYTE;
                                idx    <= load_idx;
                                shreg  <= next_byte;
                                sda_oe <= ~next_byte[7];
                            end else begin
                                state  <= ST_WR_BYTE;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_WR_BYTE: begin
                        if (scl_rise) begin
                            shreg   <= wr_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (!ptr_loaded) begin
                                    ptr        <= wr_byte;
                                    ptr_loaded <= 1'b1;
                                end else begin
                                    cfg_wr   <= 1'b1;
                                    cfg_addr <= ptr;
                                    cfg_data <= wr_byte;
                                    ptr      <= ptr + 8'd1;
                                end
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            state  <= ST_WR_ACK;
                            sda_oe <= 1'b1;
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            state   <= ST_WR_BYTE;
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b0;
                        end
                    end
                    ST_RD_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                state  <= ST_RD_ACK;
                                sda_oe <= 1'b0;
                            end else begin
                                shreg   <= {shreg[6:0], 1'b0};
                                sda_oe  <= ~shreg[6];
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        // A NACK ends the read as soon as it is sampled.
                        if (scl_rise && sda_s) begin
                            state  <= ST_IDLE;
                            sda_oe <= 1'b0;
                            busy   <= 1'b0;
                        end else if (scl_fall) begin
                            state   <= ST_RD_BYTE;
                            bit_cnt <= 4'd0;
                            idx     <= load_idx;
                            shreg   <= next_byte;
                            sda_oe  <= ~next_byte[7];
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixart_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixart_emu
// Purpose  : Directed + randomized I2C master bench for pixart_emu with a
//            report/register reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pixart_emu;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_pad;
    logic       sda_oe;
    logic [9:0] blob_x = '0;
    logic [9:0] blob_y = '0;
    logic [3:0] blob_size = '0;
    logic       blob_valid = 1'b0;
    logic       cfg_wr;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       busy;

    assign sda_pad = sda_m & ~sda_oe;

    pixart_emu dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scl_in     (scl_m),
        .sda_in     (sda_pad),
        .sda_oe     (sda_oe),
        .blob_x     (blob_x),
        .blob_y     (blob_y),
        .blob_size  (blob_size),
        .blob_valid (blob_valid),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [15:0] wr_log[$];
    int          oe_cnt   = 0;
    int          busy_cnt = 0;

    always @(negedge clk) begin
        if (cfg_wr) wr_log.push_back({cfg_addr, cfg_data});
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input int n, input int x, input int y,
                                              input int sz, input bit v);
        logic [7:0] rep [16];
        for (int k = 0; k < 16; k++) rep[k] = 8'hFF;
        rep[0] = 8'h00;
        if (v) begin
            rep[1] = 8'(x % 256);
            rep[2] = 8'(y % 256);
            rep[3] = 8'((y / 256) * 64 + (x / 256) * 16 + sz);
        end
        return rep[n % 16];
    endfunction

    task automatic wq;
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wq;
        scl_m = 1'b1; wq;
        sda_m = 1'b0; wq;
        scl_m = 1'b0; wq;
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wq;
        scl_m = 1'b1; wq;
        sda_m = 1'b1; wq;
        wq;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; wq;
        scl_m = 1'b1; wq;
        wq;
        scl_m = 1'b0; wq;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        sda_m = 1'b1; wq;
        scl_m = 1'b1; wq;
        ack = ~sda_pad;
        wq;
        scl_m = 1'b0; wq;
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] d);
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; wq;
            scl_m = 1'b1; wq;
            d = {d[6:0], sda_pad};
            wq;
            scl_m = 1'b0; wq;
        end
        write_bit(~give_ack);
    endtask

    task automatic read_report(input string tag, input int n, input int x, input int y,
                               input int sz, input bit v);
        logic       a;
        logic [7:0] d;
        blob_x = 10'(x); blob_y = 10'(y); blob_size = 4'(sz); blob_valid = v;
        i2c_start;
        write_byte(8'hB1, a);
        check($sformatf("%s_addr_ack", tag), 32'(a), 32'd1);
        for (int j = 0; j < n; j++) begin
            read_byte(j != n - 1, d);
            check($sformatf("%s_b%0d", tag, j), 32'(d), 32'(model_byte(j, x, y, sz, v)));
        end
        check($sformatf("%s_busy_after_nack", tag), 32'(busy), 32'd0);
        i2c_stop;
    endtask

    task automatic wr_txn(input string tag, input logic [7:0] p, input int n,
                          input logic [7:0] dat [4]);
        logic a;
        int   base;
        base = wr_log.size();
        i2c_start;
        write_byte(8'hB0, a);
        check($sformatf("%s_addr_ack", tag), 32'(a), 32'd1);
        write_byte(p, a);
        check($sformatf("%s_ptr_ack", tag), 32'(a), 32'd1);
        for (int k = 0; k < n; k++) begin
            write_byte(dat[k], a);
            check($sformatf("%s_d%0d_ack", tag, k), 32'(a), 32'd1);
        end
        i2c_stop;
        check($sformatf("%s_nwr", tag), 32'(wr_log.size() - base), 32'(n));
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_wr%0d", tag, k),
                  (wr_log.size() > base + k) ? 32'(wr_log[base + k]) : 32'hDEADBEEF,
                  32'(((int'(p) + k) % 256) * 256 + int'(dat[k])));
        end
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        logic [7:0] dat [4];
        int         oe0, busy0, wr0, x0, x1, ex;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_cfg_wr", 32'(cfg_wr), 32'd0);
        check("rst_cfg_addr", 32'(cfg_addr), 32'd0);
        check("rst_cfg_data", 32'(cfg_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Full 16-byte report, busy high during the transfer
        blob_x = 10'h2A5; blob_y = 10'h1C3; blob_size = 4'd4; blob_valid = 1'b1;
        i2c_start;
        write_byte(8'hB1, a);
        check("rd16_addr_ack", 32'(a), 32'd1);
        check("rd16_busy", 32'(busy), 32'd1);
        for (int j = 0; j < 16; j++) begin
            read_byte(j != 15, d);
            check($sformatf("rd16_b%0d", j), 32'(d), 32'(model_byte(j, 'h2A5, 'h1C3, 4, 1'b1)));
        end
        check("rd16_busy_after_nack", 32'(busy), 32'd0);
        i2c_stop;

        // Register writes
        dat = '{8'h01, 8'h08, 8'h00, 8'h00};
        wr_txn("wr30", 8'h30, 2, dat);

        // Pointer wraps from 0xFF to 0x00
        dat = '{8'hA7, 8'h5C, 8'h00, 8'h00};
        wr_txn("wrFF", 8'hFF, 2, dat);

        // Wrong address: ignored entirely
        oe0 = oe_cnt; busy0 = busy_cnt; wr0 = wr_log.size();
        i2c_start;
        write_byte(8'h42, a);
        check("bad_addr_ack", 32'(a), 32'd0);
        write_byte(8'h55, a);
        check("bad_data_ack", 32'(a), 32'd0);
        i2c_stop;
        check("bad_oe", 32'(oe_cnt - oe0), 32'd0);
        check("bad_busy", 32'(busy_cnt - busy0), 32'd0);
        check("bad_nwr", 32'(wr_log.size() - wr0), 32'd0);

        // Invalid blob, 18 bytes to cross the index wrap
        read_report("rd18", 18, 'h123, 'h0AB, 7, 1'b0);

        // Randomized reports and writes
        for (int r = 0; r < 3; r++) begin
            read_report($sformatf("rnd%0d", r), 5, int'($urandom_range(1023, 0)),
                        int'($urandom_range(767, 0)), int'($urandom_range(15, 0)),
                        1'($urandom_range(1, 0)));
        end
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) dat[k] = 8'($urandom_range(255, 0));
            wr_txn($sformatf("rwr%0d", r), 8'($urandom_range(255, 0)), 3, dat);
        end

        // Pointer write, repeated START, read; blob_x changes mid-report
        x0 = 'h1F0; x1 = 'h30E;
        blob_x = 10'(x0); blob_y = 10'h2FF; blob_size = 4'd9; blob_valid = 1'b1;
        wr0 = wr_log.size();
        i2c_start;
        write_byte(8'hB0, a);
        check("rs_waddr_ack", 32'(a), 32'd1);
        write_byte(8'h36, a);
        check("rs_ptr_ack", 32'(a), 32'd1);
        i2c_start;
        write_byte(8'hB1, a);
        check("rs_raddr_ack", 32'(a), 32'd1);
        check("rs_busy", 32'(busy), 32'd1);
        blob_x = 10'(x1);
`ifdef PIXART_EMU_SNAPSHOT_EN
        ex = x0;
`else
        ex = x1;
`endif
        for (int j = 0; j < 4; j++) begin
            read_byte(j != 3, d);
            check($sformatf("rs_b%0d", j), 32'(d), 32'(model_byte(j, ex, 'h2FF, 9, 1'b1)));
        end
        i2c_stop;
        check("rs_nwr", 32'(wr_log.size() - wr0), 32'd0);

        // Reset during read bit 3
        blob_valid = 1'b1;
        i2c_start;
        write_byte(8'hB1, a);
        check("rst_addr_ack", 32'(a), 32'd1);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        sda_m = 1'b1; wq;
        check("rst_pre_oe", 32'(sda_oe), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_oe", 32'(sda_oe), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        oe0 = oe_cnt;
        for (int i = 0; i < 20; i++) write_bit(1'b1);
        check("rst_quiet_oe", 32'(oe_cnt - oe0), 32'd0);
        check("rst_quiet_busy", 32'(busy), 32'd0);
        read_report("post_rst", 2, 'h0C8, 'h064, 3, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixart_emu.md
# pixart_emu

I2C target that emulates the PixArt IR camera, the responder end of the camera I2C link. It accepts the camera master's configuration writes and answers its 16-byte report reads with blob coordinates taken from input ports. It sits on the sim/test board in place of the real sensor, so the camera master, xy_leds and the SRAM write path can be exercised with known coordinates. Fully synchronous to `clk`; SCL and SDA are oversampled.

## Interface
Parameters:
- `I2C_ADDR`, 7'h58: 7-bit target address that is acknowledged.
- `SYNC_STAGES`, 2: synchroniser depth on SCL/SDA. Legal values are 2 or 3.

Ports:
- `clk` in 1: system clock, at least 16x the SCL rate.
- `reset_n` in 1: asynchronous, active-low reset.
- `scl_in` in 1: I2C clock from the master.
- `sda_in` in 1: I2C data as read back from the pad.
- `sda_oe` out 1: 1 pulls SDA low (open drain); 0 releases it.
- `blob_x` in 10: blob 1 X coordinate, 0..1023.
- `blob_y` in 10: blob 1 Y coordinate, 0..767.
- `blob_size` in 4: blob 1 size.
- `blob_valid` in 1: 0 reports "no blob".
- `cfg_wr` out 1: one-`clk` strobe per register byte written by the master.
- `cfg_addr` out 8: register address for `cfg_wr`.
- `cfg_data` out 8: register data for `cfg_wr`.
- `busy` out 1: 1 from an addressed START until STOP or a NACK release.

## Operation
- SCL and SDA pass through `SYNC_STAGES` flops, followed by a one-flop edge detect.
- Bus conditions:
  - START: synced SDA falls while synced SCL is high.
  - STOP: synced SDA rises while synced SCL is high.
- State machine: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
  - START from any state goes to ADDR with the bit counter cleared. This also covers repeated START.
  - STOP from any state goes to IDLE, with `sda_oe`=0 and `busy`=0.
  - ADDR shifts 8 bits, MSB first, sampling on rising SCL.
  - Address match with R/W=0 goes to ADDR_ACK, then WR_BYTE.
  - Address match with R/W=1 goes to ADDR_ACK, then RD_BYTE.
  - Address mismatch: no ACK, return to IDLE and ignore the bus until the next START.
- Write transactions:
  - The first data byte after the address loads the 8-bit register pointer `ptr`.
  - Each later byte pulses `cfg_wr` with `cfg_addr`=`ptr` and `cfg_data`=the byte, then increments `ptr` mod 256.
  - Every write byte is ACKed.
- Read transactions return a 16-byte report. The report index resets to 0 at each read address ACK and wraps from 15 to 0.
  - Byte 0: 0x00.
  - Byte 1: X[7:0].
  - Byte 2: Y[7:0].
  - Byte 3: {Y[9:8], X[9:8], size[3:0]}.
  - Bytes 4..15: 0xFF.
  - If `blob_valid`=0, bytes 1..3 are also 0xFF.
  - After each read byte the master's ACK is sampled: ACK loads the next byte; NACK releases SDA and goes to IDLE.
- `ptr` keeps its value across transactions and is cleared by reset only.

## Timing
- Reset values:
  - `sda_oe`=0, `cfg_wr`=0, `cfg_addr`=0, `cfg_data`=0, `busy`=0.
  - State=IDLE, `ptr`=0.
- SDA changes are issued only after a synced falling SCL edge. This gives a latency of `SYNC_STAGES`+1 clocks from the pad edge.
- ACK: `sda_oe`=1 from the falling SCL after bit 8 until the falling SCL after bit 9.
- Read data:
  - Bit 7 is driven from the falling SCL that ends the address ACK, or the previous master ACK.
  - Each following bit is driven on the next falling SCL.
  - `sda_oe` equals the inverted data bit.
- `cfg_wr` pulses on the `clk` after the rising SCL of bit 8 (the eighth data bit) is detected.
- `busy` rises with ADDR_ACK and falls on the `clk` that IDLE is entered.
- `reset_n` asserted mid-transfer immediately releases SDA. The block then ignores the bus until a new START.

## Configuration
- `PIXART_EMU_SNAPSHOT_EN` defined: `blob_x`, `blob_y`, `blob_size` and `blob_valid` are captured once at the read address ACK, so a whole report is coherent.
- `PIXART_EMU_SNAPSHOT_EN` undefined: each report byte is built from the live inputs when that byte is loaded into the shifter. This saves 25 flops.

## Test plan
- Address 0x58 with R/W=1, inputs x=0x2A5, y=0x1C3, size=4, valid=1, read 16 bytes with NACK on the last -> ACK on the address; data 00 A5 C3 64, then 12 bytes of FF; `busy` falls after the NACK.
- Write 0x58: 0x30, 0x01, 0x08 -> two `cfg_wr` pulses, carrying (0x30,0x01) then (0x31,0x08); all 4 bytes ACKed.
- Address 0x21 write -> no ACK, `sda_oe` stays 0 for the whole transfer, no `cfg_wr` pulse, `busy`=0.
- Read 18 bytes with valid=0 -> byte 0 is 00, then FF up to byte 15, then bytes 16..17 are 00 FF (index wrap).
- Write 0x58: 0x36, then repeated START and a read -> report starts at byte 0, and `ptr`=0x36 is retained. In snapshot mode, changing `blob_x` during the read leaves bytes 1..3 unchanged.
- `reset_n` pulsed low during read bit 3 -> `sda_oe`=0 within the same cycle, and nothing is driven until the next valid START.
